// File: rtl/inference_bram_sequencer.sv
// inference_bram_sequencer
//
// Walks BRAM port B from a base address and presents each feature/clause
// word to the Tsetlin inference core. A read of FFFF_FFFF means the producer
// has not written that word yet (hold): the same address is re-read, bounded
// by STALL_MAX consecutive holds. A read of FFFF_FF00 ends the stream and
// kicks the core. Data words beyond MAX_WORDS abort the run. When the core
// reports done, the per-image predicted classes are latched.
//
// State table:
//   state   | meaning
//   IDLE    | after reset, waiting for i_start
//   ISSUE   | o_enb high, BRAM samples o_addrb
//   EVAL    | i_doutb valid, classify hold / end / data
//   COMPUTE | core running, waiting for i_core_done
//   DONE    | o_predicted_class valid, o_result_ready held high
//   ERROR   | run aborted (stall timeout or word overflow), o_error held high
//
// Ports:
//   i_clock, i_reset        single clock, synchronous active-high reset
//   i_start, i_base_addr    run request and byte start address (bits [1:0] ignored)
//   o_addrb..o_rstb, i_doutb BRAM port B (read-only use, 1-cycle read latency)
//   o_word_*                one-cycle strobe and fields of an accepted data word
//   o_core_start, i_core_done, i_core_class  inference core handshake
//   o_predicted_class, o_result_ready        latched results
//   o_busy, o_word_count, o_error            status

module inference_bram_sequencer #(
    parameter int CLAUSE_LEN = 9,
    parameter int CLASS_LEN  = 4,
    parameter int IMAGES     = 8,
    parameter int MAX_WORDS  = 1024,
    parameter int STALL_MAX  = 4096
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic [31:0]                 i_base_addr,
    output logic [31:0]                 o_addrb,
    output logic                        o_enb,
    output logic [3:0]                  o_web,
    output logic [31:0]                 o_dinb,
    output logic                        o_rstb,
    input  logic [31:0]                 i_doutb,
    output logic                        o_word_valid,
    output logic [7:0]                  o_word_data,
    output logic [CLASS_LEN-1:0]        o_word_class,
    output logic [CLAUSE_LEN-1:0]       o_word_clause,
    output logic                        o_core_start,
    input  logic                        i_core_done,
    input  logic [IMAGES*CLASS_LEN-1:0] i_core_class,
    output logic [IMAGES*CLASS_LEN-1:0] o_predicted_class,
    output logic                        o_result_ready,
    output logic                        o_busy,
    output logic [15:0]                 o_word_count,
    output logic                        o_error
);

    localparam int          SW       = $clog2(STALL_MAX + 1);
    localparam logic [31:0] HOLD_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] END_WORD  = 32'hFFFF_FF00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_EVAL,
        S_COMPUTE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                        r_state;
    logic [31:0]                   r_addrb;
    logic                          r_enb;
    logic                          r_word_valid;
    logic [7:0]                    r_word_data;
    logic [CLASS_LEN-1:0]          r_word_class;
    logic [CLAUSE_LEN-1:0]         r_word_clause;
    logic                          r_core_start;
    logic [IMAGES*CLASS_LEN-1:0]   r_predicted_class;
    logic                          r_result_ready;
    logic                          r_busy;
    logic [15:0]                   r_word_count;
    logic                          r_error;
    logic [SW-1:0]                 r_stall_cnt;

    logic [SW-1:0]                 w_stall_next;
    logic                          w_unused;

    assign w_stall_next = r_stall_cnt + 1'b1;
    // Address alignment bits and the gap between clause and data fields are don't-care.
    assign w_unused     = ^{i_base_addr[1:0], i_doutb[18:8]};

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state           <= S_IDLE;
            r_addrb           <= '0;
            r_enb             <= 1'b0;
            r_word_valid      <= 1'b0;
            r_word_data       <= '0;
            r_word_class      <= '0;
            r_word_clause     <= '0;
            r_core_start      <= 1'b0;
            r_predicted_class <= '0;
            r_result_ready    <= 1'b0;
            r_busy            <= 1'b0;
            r_word_count      <= '0;
            r_error           <= 1'b0;
            r_stall_cnt       <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            r_word_valid <= 1'b0;
            r_core_start <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_start) begin
                        r_addrb        <= {i_base_addr[31:2], 2'b00};
                        r_word_count   <= '0;
                        r_stall_cnt    <= '0;
                        r_result_ready <= 1'b0;
                        r_error        <= 1'b0;
                        r_enb          <= 1'b1;
                        r_busy         <= 1'b1;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_enb   <= 1'b0;
                    r_state <= S_EVAL;
                end
                S_EVAL: begin
                    if (i_doutb == HOLD_WORD) begin
                        r_stall_cnt <= w_stall_next;
                        if (w_stall_next == SW'(STALL_MAX)) begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_ERROR;
                        end else begin
                            r_enb   <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end else if (i_doutb == END_WORD) begin
                        r_core_start <= 1'b1;
                        r_state      <= S_COMPUTE;
                    end else if (r_word_count == 16'(MAX_WORDS)) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_ERROR;
                    end else begin
                        r_word_valid  <= 1'b1;
                        r_word_data   <= i_doutb[7:0];
                        r_word_class  <= i_doutb[31:28];
                        r_word_clause <= i_doutb[27:19];
                        r_word_count  <= r_word_count + 16'd1;
                        r_addrb       <= r_addrb + 32'd4;
                        r_stall_cnt   <= '0;
                        r_enb         <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_COMPUTE: begin
                    if (i_core_done) begin
                        r_predicted_class <= i_core_class;
                        r_result_ready    <= 1'b1;
                        r_busy            <= 1'b0;
                        r_state           <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_addrb           = r_addrb;
    assign o_enb             = r_enb;
    assign o_web             = 4'b0000;
    assign o_dinb            = 32'd0;
    assign o_rstb            = 1'b0;
    assign o_word_valid      = r_word_valid;
    assign o_word_data       = r_word_data;
    assign o_word_class      = r_word_class;
    assign o_word_clause     = r_word_clause;
    assign o_core_start      = r_core_start;
    assign o_predicted_class = r_predicted_class;
    assign o_result_ready    = r_result_ready;
    assign o_busy            = r_busy;
    assign o_word_count      = r_word_count;
    assign o_error           = r_error;

endmodule
